nt_pipe_cell: RTL and testbench

Parametrised, handshaked successor of the single-bit NT node subcircuit. Computes the history-feedback NAND/AND node function over WIDTH-bit vectors, adds a valid/ready handshake, a STAGES-deep bubble-collapsing register pipeline, a bypass mode and a saturating beat counter. It is the reusable building block for the Nt_Node_Subcircuits benchmark generator. Instances are chained into larger trojan-detection test netlists.

---
 rtl/nt_pkg.sv | 33 +++
 rtl/nt_pipe_stage.sv | 35 +++
 rtl/nt_pipe_cell.sv | 100 ++++++++++
 tb/tb_nt_pipe_cell.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nt_pkg.sv
// Shared definitions for the NT node pipeline cell: default parameters and
// the bitwise history-feedback node function used by the RTL, generator
// scripts and reference models.
package nt_pkg;

  // Default build parameters for nt_pipe_cell instances
  localparam int NT_DEF_WIDTH  = 1;
  localparam int NT_DEF_STAGES = 2;
  localparam int NT_DEF_CNT_W  = 8;

  // Widest vector the node function handles; callers zero-extend their
  // operands to this width and truncate the result back to their own width.
  localparam int NT_MAX_W = 64;

  typedef logic [NT_MAX_W-1:0] nt_vec_t;

  // Bitwise NT node: NAND of the operands, folded with the previous beat's
  // operand A (hist) and gated by the side operand captured with the
  // previous beat (gside).
  function automatic nt_vec_t nt_node_f(input nt_vec_t hist,
                                        input nt_vec_t gside,
                                        input nt_vec_t a,
                                        input nt_vec_t b);
    nt_vec_t p;
    nt_vec_t t;
    nt_vec_t u;
    p = ~(a & b);
    t = ~(~hist & p);
    u = ~(t & gside);
    return t & u;
  endfunction

endpackage

// File: rtl/nt_pipe_stage.sv
// One valid/data register slice of the bubble-collapsing pipeline. The slice
// loads whenever it is empty or its downstream neighbour is taking its
// current contents, so empty slots fill even while the output is stalled.
module nt_pipe_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  input  logic             down_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic load;

  assign load     = ~valid | down_ready;
  assign up_ready = load;

  // Capture the upstream beat when this slot is free or being drained
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/nt_pipe_cell.sv
// Handshaked, pipelined NT node cell. Stage 0 evaluates the node function
// on accepted beats using the history (previous operand A) and gated side
// operand (previous in_side); the result then travels through STAGES
// register slices. A saturating counter tallies output handshakes.
// WIDTH must not exceed nt_pkg::NT_MAX_W.
module nt_pipe_cell
  import nt_pkg::*;
#(
  parameter int WIDTH  = NT_DEF_WIDTH,
  parameter int STAGES = NT_DEF_STAGES,
  parameter int CNT_W  = NT_DEF_CNT_W
) (
  input  logic             I1470,
  input  logic             I1477,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_side,
  input  logic             bypass,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNT_W-1:0] beat_cnt
);

  logic [WIDTH-1:0] hist;
  logic [WIDTH-1:0] gside;
  logic [WIDTH-1:0] node_y;
  logic             accept;

  logic             stage_valid [STAGES];
  logic [WIDTH-1:0] stage_data  [STAGES];
  logic             stage_ready [STAGES+1];

  // The last slice drains into the consumer; the ready chain ripples back
  // from there, so out_ready reaches in_ready combinationally.
  assign stage_ready[STAGES] = out_ready;
  assign in_ready            = stage_ready[0];
  assign accept              = in_valid & stage_ready[0];

  assign out_valid = stage_valid[STAGES-1];
  assign out_y     = stage_data[STAGES-1];

  // Node evaluation for the beat currently offered; bypass forwards operand A
  always_comb begin
    node_y = WIDTH'(nt_node_f(nt_vec_t'(hist), nt_vec_t'(gside),
                              nt_vec_t'(in_a), nt_vec_t'(in_b)));
    if (bypass) begin
      node_y = in_a;
    end
  end

  // History and side operand advance on every accepted beat, bypass or not
  always_ff @(posedge I1470) begin
    if (I1477) begin
      hist  <= '0;
      gside <= '0;
    end else if (accept) begin
      hist  <= in_a;
      gside <= in_side;
    end
  end

  // Output handshake counter that sticks at its maximum value
  always_ff @(posedge I1470) begin
    if (I1477) begin
      beat_cnt <= '0;
    end else if (out_valid && out_ready && (beat_cnt != {CNT_W{1'b1}})) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = node_y;
    end else begin : g_body
      assign up_valid = stage_valid[i-1];
      assign up_data  = stage_data[i-1];
    end

    nt_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clock      (I1470),
      .reset      (I1477),
      .up_valid   (up_valid),
      .up_data    (up_data),
      .up_ready   (stage_ready[i]),
      .down_ready (stage_ready[i+1]),
      .valid      (stage_valid[i]),
      .data       (stage_data[i])
    );
  end

endmodule

// File: tb/tb_nt_pipe_cell.sv
// Self-checking bench for nt_pipe_cell. A queue model tracks every beat
// in flight and its position, and predicts the outputs each cycle; directed
// sequences pin the model with hand-computed values.
module tb_nt_pipe_cell;

  localparam int W       = 4;
  localparam int S       = 3;
  localparam int CW      = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          in_valid  = 1'b0;
  logic          bypass    = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  in_a      = '0;
  logic [W-1:0]  in_b      = '0;
  logic [W-1:0]  in_side   = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_y;
  logic [CW-1:0] beat_cnt;

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    logic [W-1:0] y;
    int           pos;
  } beat_t;

  beat_t        mPipe[$];
  logic [W-1:0] mHist   = '0;
  logic [W-1:0] mGside  = '0;
  int           mCnt    = 0;
  bit           checking = 1'b0;
  bit           expValid;
  bit           expReady;
  logic [W-1:0] expY;

  logic [W-1:0] pinY [5] = '{4'hF, 4'h0, 4'h0, 4'hF, 4'hF};

  nt_pipe_cell #(
    .WIDTH (W),
    .STAGES(S),
    .CNT_W (CW)
  ) dut (
    .I1470    (clk),
    .I1477    (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_side  (in_side),
    .bypass   (bypass),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [W-1:0] s,
                               input bit byp, input bit ordy);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_side   = s;
    bypass    = byp;
    out_ready = ordy;
  endtask

  // Reference model: predict this cycle's outputs, compare, then advance
  // the set of in-flight beats by one clock using the sampled inputs.
  always @(negedge clk) begin
    int           occ;
    int           lim;
    int           np;
    bit           accept;
    bit           popped;
    beat_t        e;
    logic [W-1:0] ny;

    occ      = mPipe.size();
    expValid = (occ > 0) && (mPipe[0].pos == S - 1);
    expY     = expValid ? mPipe[0].y : '0;
    expReady = !((occ == S) && !out_ready);

    if (checking) begin
      checkOutput("out_valid", 32'(out_valid), 32'(expValid));
      if (expValid) checkOutput("out_y", 32'(out_y), 32'(expY));
      checkOutput("in_ready", 32'(in_ready), 32'(expReady));
      checkOutput("beat_cnt", 32'(beat_cnt), 32'(mCnt));
    end

    if (rst) begin
      mPipe.delete();
      mHist    = '0;
      mGside   = '0;
      mCnt     = 0;
      checking = 1'b1;
    end else if (checking) begin
      accept = in_valid && expReady;
      popped = expValid && out_ready;
      if (popped) begin
        void'(mPipe.pop_front());
        if (mCnt < CNT_MAX) mCnt++;
      end
      // each beat moves one slot forward unless blocked by the beat ahead
      lim = S;
      for (int i = 0; i < mPipe.size(); i++) begin
        e  = mPipe[i];
        np = e.pos + 1;
        if (np > lim - 1) np = lim - 1;
        e.pos    = np;
        mPipe[i] = e;
        lim      = np;
      end
      if (accept) begin
        ny = bypass ? in_a : ((mHist | (in_a & in_b)) & ~mGside);
        e.y   = ny;
        e.pos = 0;
        mPipe.push_back(e);
        mHist  = in_a;
        mGside = in_side;
      end
    end
  end

  initial begin
    int           waited;
    int           acc;
    bit           rr;
    bit           rv;
    bit           rb;
    bit           ro;
    logic [W-1:0] ra;
    logic [W-1:0] rbv;
    logic [W-1:0] rs;

    applyStimulus(1, 0, '0, '0, '0, 0, 1);
    applyStimulus(1, 0, '0, '0, '0, 0, 1);

    // Directed beats with out_ready held high: latency, node values, bypass
    applyStimulus(0, 1, 4'hF, 4'hF, 4'hF, 0, 1);
    fork
      begin
        applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 0, 1);
        applyStimulus(0, 1, 4'h0, 4'hF, 4'h0, 0, 1);
        applyStimulus(0, 1, 4'hF, 4'h0, 4'h0, 1, 1);
        applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 0, 1);
        applyStimulus(0, 0, 4'h0, 4'h0, 4'h0, 0, 1);
      end
      begin
        waited = 0;
        do begin
          @(negedge clk);
          #1;
          waited++;
        end while (!out_valid && waited < 20);
        checkOutput("pin_latency", 32'(waited), 32'(S + 1));
        for (int k = 0; k < 5; k++) begin
          checkOutput("pin_valid", 32'(out_valid), 32'(1));
          checkOutput("pin_y", 32'(out_y), 32'(pinY[k]));
          checkOutput("pin_model_y", 32'(expY), 32'(pinY[k]));
          @(negedge clk);
          #1;
        end
        checkOutput("pin_cnt5", 32'(beat_cnt), 32'(5));
      end
    join

    // Backpressure: with the output stalled only S beats fit
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      ra  = W'($urandom);
      rbv = W'($urandom);
      rs  = W'($urandom);
      applyStimulus(0, 1, ra, rbv, rs, 0, 0);
      @(negedge clk);
      #1;
      if (in_ready) acc++;
    end
    checkOutput("pin_accepts", 32'(acc), 32'(S));
    applyStimulus(0, 0, '0, '0, '0, 0, 1);
    repeat (6) applyStimulus(0, 0, '0, '0, '0, 0, 1);
    @(negedge clk);
    #1;
    checkOutput("pin_cnt_sat", 32'(beat_cnt), 32'(CNT_MAX));

    // Reset with two beats in flight, then a beat that must see hist=gside=0
    applyStimulus(0, 1, 4'hF, 4'hF, 4'hF, 0, 0);
    applyStimulus(0, 1, 4'hF, 4'hF, 4'hF, 0, 0);
    applyStimulus(1, 0, '0, '0, '0, 0, 0);
    applyStimulus(0, 0, '0, '0, '0, 0, 1);
    @(negedge clk);
    #1;
    checkOutput("pin_rst_valid", 32'(out_valid), 32'(0));
    checkOutput("pin_rst_cnt", 32'(beat_cnt), 32'(0));
    checkOutput("pin_rst_ready", 32'(in_ready), 32'(1));
    applyStimulus(0, 1, 4'hF, 4'h5, 4'h0, 0, 1);
    applyStimulus(0, 0, '0, '0, '0, 0, 1);
    waited = 0;
    while (!out_valid && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("pin_post_rst_valid", 32'(out_valid), 32'(1));
    checkOutput("pin_post_rst_y", 32'(out_y), 32'(4'h5));
    checkOutput("pin_post_rst_model", 32'(expY), 32'(4'h5));

    // Randomized traffic with random backpressure, bypass and resets
    for (int i = 0; i < 3000; i++) begin
      rr  = ($urandom_range(0, 249) == 0);
      rv  = ($urandom_range(0, 9) < 7);
      rb  = ($urandom_range(0, 7) == 0);
      ro  = ($urandom_range(0, 9) < 6);
      ra  = W'($urandom);
      rbv = W'($urandom);
      rs  = W'($urandom);
      applyStimulus(rr, rv, ra, rbv, rs, rb, ro);
    end
    repeat (8) applyStimulus(0, 0, '0, '0, '0, 0, 1);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", nPass, nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
